// File: rtl/lib_arb.sv
// Shared types for the memory port arbiter: FSM states, owner encoding, counter width.
package lib_arb;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between CPU (req[0]) and debug (req[1]).
// MEM_PORT_ARB_RR_EN selects round-robin; otherwise the CPU has fixed priority.
module arb_pick
    import lib_arb::*;
(
    input  logic [1:0] req,
`ifdef MEM_PORT_ARB_RR_EN
    input  owner_e     last_grant,
`endif
    output owner_e     winner,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
`ifdef MEM_PORT_ARB_RR_EN
        // On contention the requester that did not win last time goes first.
        if (req == 2'b11) begin
            winner = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else begin
            winner = req[0] ? OWN_CPU : OWN_DBG;
        end
`else
        winner = req[0] ? OWN_CPU : OWN_DBG;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the CPU and the debug/loader master.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration instead of fixed CPU priority.
module mem_port_arbiter
    import lib_arb::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MEM_LAT - 1);

    arb_state_e       state;
    owner_e           owner;
    logic [CNT_W-1:0] cnt;
    owner_e           winner;
    logic             grant_valid;
    logic             sel_dbg;

`ifdef MEM_PORT_ARB_RR_EN
    owner_e last_grant;
`endif

    arb_pick u_arb_pick (
        .req         (req),
`ifdef MEM_PORT_ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    assign sel_dbg = (winner == OWN_DBG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_CPU;
            cnt       <= '0;
            done      <= 2'b00;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_grant <= OWN_CPU;
`endif
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        // mem_we is registered here so it is high only in the first ACCESS cycle.
                        mem_addr  <= sel_dbg ? addr1 : addr0;
                        mem_wdata <= sel_dbg ? wdata1 : wdata0;
                        mem_we    <= sel_dbg ? we[1] : we[0];
                        owner     <= winner;
                        cnt       <= CntLoad;
                        busy      <= 1'b1;
                        state     <= ARB_ACCESS;
`ifdef MEM_PORT_ARB_RR_EN
                        last_grant <= winner;
`endif
                    end
                end
                ARB_ACCESS: begin
                    mem_we <= 1'b0;
                    if (cnt == '0) begin
                        rdata <= mem_rdata;
                        done  <= (owner == OWN_DBG) ? 2'b10 : 2'b01;
                        busy  <= 1'b0;
                        state <= ARB_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARB_DONE: begin
                    done  <= 2'b00;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: one arbiter at MEM_LAT=2 and one at MEM_LAT=1 on shared stimulus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [1:0]  done, done1;
    logic [31:0] rdata, rdata1;
    logic        busy, busy1;
    logic [31:0] mem_addr, mem_addr1, mem_wdata, mem_wdata1, mem_rdata, mem_rdata1;
    logic        mem_we, mem_we1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : a * 3 + 32'h1000;
    endfunction

    // Address is held stable through ACCESS, so a combinational lookup models the memory.
    assign mem_rdata  = rd_fn(mem_addr);
    assign mem_rdata1 = rd_fn(mem_addr1);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done      (done1),
        .rdata     (rdata1),
        .busy      (busy1),
        .mem_addr  (mem_addr1),
        .mem_wdata (mem_wdata1),
        .mem_we    (mem_we1),
        .mem_rdata (mem_rdata1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the selected instance pulses done (bounded); tally mem_we pulses on the way.
    task automatic wait_done(input bit sel, output logic [1:0] d, output int cyc,
                             output int we_cnt, output logic [31:0] wa, output logic [31:0] wd);
        d = 2'b00; cyc = 0; we_cnt = 0; wa = '0; wd = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (sel ? mem_we1 : mem_we) begin
                we_cnt++;
                wa = sel ? mem_addr1 : mem_addr;
                wd = sel ? mem_wdata1 : mem_wdata;
            end
            if ((sel ? done1 : done) != 2'b00) begin
                d   = sel ? done1 : done;
                cyc = i;
                break;
            end
        end
    endtask

    logic [1:0]  d;
    int          cyc, wec, cnt;
    logic [31:0] wa, wd;
    logic [1:0]  exp_own [3];
    logic [31:0] exp_rd  [3];

    initial begin
        reset = 1'b1; req = '0; we = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) step();
        check("rst_done", done, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        step();

        // CPU read at MEM_LAT=2
        req = 2'b01; we = 2'b00; addr0 = 32'h40;
        step();
        check("rd_mem_addr", mem_addr, 32'h40);
        check("rd_busy", busy, 1'b1);
        check("rd_mem_we", mem_we, 1'b0);
        step();
        check("rd_done_early", done, 2'b00);
        step();
        check("rd_done", done, 2'b01);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_busy_done", busy, 1'b0);
        req = 2'b00;
        step();
        check("rd_done_once", done, 2'b00);

        // Debug write
        req = 2'b10; we = 2'b10; addr1 = 32'h80; wdata1 = 32'h1234_5678;
        wait_done(1'b0, d, cyc, wec, wa, wd);
        check("wr_done", d, 2'b10);
        check("wr_latency", cyc, 3);
        check("wr_we_pulses", wec, 1);
        check("wr_addr", wa, 32'h80);
        check("wr_wdata", wd, 32'h1234_5678);
        req = 2'b00; we = 2'b00;
        step();

        // Contention from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
        exp_own[0] = 2'b10; exp_own[1] = 2'b01; exp_own[2] = 2'b10;
        exp_rd[0] = 32'h1600; exp_rd[1] = 32'h1300; exp_rd[2] = 32'h1600;
`else
        exp_own[0] = 2'b01; exp_own[1] = 2'b01; exp_own[2] = 2'b01;
        exp_rd[0] = 32'h1300; exp_rd[1] = 32'h1300; exp_rd[2] = 32'h1300;
`endif
        req = 2'b11; we = 2'b00; addr0 = 32'h100; addr1 = 32'h200;
        for (int g = 0; g < 3; g++) begin
            wait_done(1'b0, d, cyc, wec, wa, wd);
            check($sformatf("arb_owner%0d", g), d, exp_own[g]);
            check($sformatf("arb_rdata%0d", g), rdata, exp_rd[g]);
            check($sformatf("arb_spacing%0d", g), cyc, (g == 0) ? 3 : 4);
        end
        req = 2'b00;
        repeat (3) step();

        // Withdrawal after grant
        req = 2'b01; addr0 = 32'h44;
        step();
        req = 2'b00;
        check("wd_busy", busy, 1'b1);
        wait_done(1'b0, d, cyc, wec, wa, wd);
        check("wd_done", d, 2'b01);
        check("wd_latency", cyc, 2);
        check("wd_rdata", rdata, 32'h10CC);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy) cnt++;
        end
        check("wd_no_regrant", cnt, 0);

        // Reset during the second ACCESS cycle of a write
        req = 2'b01; we = 2'b01; addr0 = 32'h300; wdata0 = 32'h0000_CAFE;
        step();
        check("rw_we_first", mem_we, 1'b1);
        req = 2'b00; we = 2'b00;
        step();
        check("rw_we_second", mem_we, 1'b0);
        check("rw_busy_second", busy, 1'b1);
        reset = 1'b1;
        step();
        check("rw_done", done, 2'b00);
        check("rw_mem_we", mem_we, 1'b0);
        check("rw_rdata", rdata, 32'h0);
        check("rw_busy", busy, 1'b0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_we || done != 2'b00) cnt++;
        end
        check("rw_no_reissue", cnt, 0);

        // MEM_LAT=1 back-to-back CPU reads
        req = 2'b01; we = 2'b00; addr0 = 32'h0;
        wait_done(1'b1, d, cyc, wec, wa, wd);
        check("l1_done0", d, 2'b01);
        check("l1_latency0", cyc, 2);
        check("l1_rdata0", rdata1, 32'h1000);
        addr0 = 32'h4;
        wait_done(1'b1, d, cyc, wec, wa, wd);
        check("l1_done1", d, 2'b01);
        check("l1_spacing", cyc, 3);
        check("l1_rdata1", rdata1, 32'h100C);
        req = 2'b00;
        repeat (3) step();
        check("l1_idle", busy1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
